// File: rtl/mult_hilo_unit_if.sv
// mult_hilo_unit_if: CPU request/HI-LO bus plus multiplier datapath link
// Ports: Start/OpA/OpB (MULTU request), ReadHi/ReadLo/WrHi/WrLo/WrData (MFHI/MFLO/MTHI/MTLO),
// HiLoOut/Busy/Stall/Done/Overrun (status and read data), MulA/MulB/MulSy/MulProduct (multiplier side).
interface mult_hilo_unit_if #(parameter int WIDTH = 16);
  logic Start;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic ReadHi;
  logic ReadLo;
  logic WrHi;
  logic WrLo;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] HiLoOut;
  logic Busy;
  logic Stall;
  logic Done;
  logic Overrun;
  logic [WIDTH-1:0] MulA;
  logic [WIDTH-1:0] MulB;
  logic MulSy;
  logic [2*WIDTH-1:0] MulProduct;
  modport master (
    output Start, OpA, OpB, ReadHi, ReadLo, WrHi, WrLo, WrData, MulProduct,
    input HiLoOut, Busy, Stall, Done, Overrun, MulA, MulB, MulSy
  );
  modport slave (
    input Start, OpA, OpB, ReadHi, ReadLo, WrHi, WrLo, WrData, MulProduct,
    output HiLoOut, Busy, Stall, Done, Overrun, MulA, MulB, MulSy
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: MULTU front end that issues the multiplier, waits its latency and holds HI/LO
// Ports: Clk, Reset (sync, active-high), bus (slave view of mult_hilo_unit_if).
module mult_hilo_unit #(
  parameter int WIDTH = 16,
  parameter int LATENCY = 34
) (
  input logic Clk,
  input logic Reset,
  mult_hilo_unit_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, mul_a, mul_b;
  logic busy, done, overrun, mul_sy;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      mul_a <= '0;
      mul_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      mul_sy <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.Start && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.WrHi) hi <= bus.WrData;
          if (bus.WrLo) lo <= bus.WrData;
          if (bus.Start) begin
            mul_a <= bus.OpA;
            mul_b <= bus.OpB;
            mul_sy <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mul_sy <= 1'b0;
          cnt <= CW'(LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi <= bus.MulProduct[2*WIDTH-1:WIDTH];
            lo <= bus.MulProduct[WIDTH-1:0];
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.HiLoOut = bus.ReadHi ? hi : lo;
  assign bus.Busy = busy;
  assign bus.Stall = busy & (bus.ReadHi | bus.ReadLo | bus.WrHi | bus.WrLo);
  assign bus.Done = done;
  assign bus.Overrun = overrun;
  assign bus.MulA = mul_a;
  assign bus.MulB = mul_b;
  assign bus.MulSy = mul_sy;
endmodule
